comms_sequencer: RTL and testbench

Frame-level controller sitting directly behind the rx block in the PICC digital core.
- Tracks each PCD frame from rx soc to eoc: counts bytes, collects errors, captures the last received bit.
- Runs the ISO/IEC 14443A frame delay time (FDT) timer after a good frame.
- Schedules the PICC response: grants the transmitter on the exact FDT slot, or a later slot on the 128-cycle grid.
- Masks rx activity while the PICC is transmitting.

---
 rtl/comms_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_comms_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/comms_sequencer.sv
// Frame-level sequencer behind the rx block: tracks each PCD frame from soc
// to eoc, runs the frame delay timer after a good frame, grants the
// transmitter on the FDT slot grid and masks rx while the PICC transmits.
module comms_sequencer #(
  parameter int FDT_LAST_BIT_1 = 1236,
  parameter int FDT_LAST_BIT_0 = 1172
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_soc,
  input  logic       rx_eoc,
  input  logic [7:0] rx_data,
  input  logic [2:0] rx_data_bits,
  input  logic       rx_data_valid,
  input  logic       rx_sequence_error,
  input  logic       rx_parity_error,
  input  logic       app_tx_req,
  input  logic       tx_done,
  output logic       rx_frame_done,
  output logic       rx_frame_error,
  output logic [7:0] rx_byte_count,
  output logic       rx_last_bit,
  output logic       tx_go,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_FDT_WAIT, S_TX_READY, S_TX_ACTIVE
  } state_t;

  // Timer is loaded with T-1 so that it reads 1 in the cycle just before
  // slot 0; the registered tx_go then lands exactly on cycle E+T.
  localparam logic [10:0] LOAD_1 = 11'(FDT_LAST_BIT_1 - 1);
  localparam logic [10:0] LOAD_0 = 11'(FDT_LAST_BIT_0 - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        lb_q, lb_d;
  logic [10:0] timer_q, timer_d;
  logic [6:0]  slot_q, slot_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic [7:0]  byte_count_q, byte_count_d;
  logic        last_bit_q, last_bit_d;
  logic        tx_go_q, tx_go_d;
  logic        busy_q, busy_d;

  logic [7:0]  acc_cnt;
  logic        acc_err;
  logic        acc_lb;
  logic        frame_bad;
  logic        slot0_hit;
  logic        slotk_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic last_bit_of(input logic [7:0] d, input logic [2:0] bits);
    logic [2:0] idx;
    idx = (bits == 3'd0) ? 3'd7 : bits - 3'd1;
    return d[idx];
  endfunction

  // Frame accumulators including this cycle's rx events (so events coincident with eoc count)
  always_comb begin
    acc_cnt = cnt_q;
    acc_lb  = lb_q;
    acc_err = err_q | rx_sequence_error | rx_parity_error;
    if (rx_data_valid) begin
      acc_cnt = sat_inc(cnt_q);
      acc_lb  = last_bit_of(rx_data, rx_data_bits);
    end
    frame_bad = acc_err | (acc_cnt == 8'd0);
    slot0_hit = (timer_q == 11'd1);
    slotk_hit = (slot_q == 7'd127);
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      lb_q          <= 1'b0;
      timer_q       <= '0;
      slot_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      byte_count_q  <= '0;
      last_bit_q    <= 1'b0;
      tx_go_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      lb_q          <= lb_d;
      timer_q       <= timer_d;
      slot_q        <= slot_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      byte_count_q  <= byte_count_d;
      last_bit_q    <= last_bit_d;
      tx_go_q       <= tx_go_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state decision; rx_soc beats a coincident slot, eoc ends the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (rx_soc) state_d = S_RX;
      S_RX:        if (rx_eoc) state_d = frame_bad ? S_IDLE : S_FDT_WAIT;
      S_FDT_WAIT: begin
        if (rx_soc)         state_d = S_RX;
        else if (slot0_hit) state_d = app_tx_req ? S_TX_ACTIVE : S_TX_READY;
      end
      S_TX_READY: begin
        if (rx_soc)                       state_d = S_RX;
        else if (slotk_hit && app_tx_req) state_d = S_TX_ACTIVE;
      end
      S_TX_ACTIVE: if (tx_done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and output updates per state
  always_comb begin
    cnt_d         = cnt_q;
    err_d         = err_q;
    lb_d          = lb_q;
    timer_d       = timer_q;
    slot_d        = slot_q;
    frame_done_d  = 1'b0;
    frame_error_d = frame_error_q;
    byte_count_d  = byte_count_q;
    last_bit_d    = last_bit_q;
    tx_go_d       = 1'b0;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (rx_soc) begin
          cnt_d = '0;
          err_d = 1'b0;
          lb_d  = 1'b0;
        end
      end
      S_RX: begin
        if (rx_eoc) begin
          frame_done_d  = 1'b1;
          frame_error_d = frame_bad;
          byte_count_d  = acc_cnt;
          last_bit_d    = acc_lb;
          cnt_d         = acc_cnt;
          err_d         = acc_err;
          lb_d          = acc_lb;
          if (!frame_bad) timer_d = acc_lb ? LOAD_1 : LOAD_0;
        end else if (rx_soc) begin
          cnt_d = '0;
          err_d = 1'b0;
          lb_d  = 1'b0;
        end else begin
          cnt_d = acc_cnt;
          err_d = acc_err;
          lb_d  = acc_lb;
        end
      end
      S_FDT_WAIT: begin
        if (rx_soc) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          lb_d    = 1'b0;
          timer_d = '0;
        end else if (slot0_hit) begin
          timer_d = '0;
          slot_d  = '0;
          tx_go_d = app_tx_req;
        end else begin
          timer_d = timer_q - 11'd1;
        end
      end
      S_TX_READY: begin
        if (rx_soc) begin
          cnt_d = '0;
          err_d = 1'b0;
          lb_d  = 1'b0;
        end else begin
          slot_d  = slot_q + 7'd1;
          tx_go_d = slotk_hit && app_tx_req;
        end
      end
      default: ;
    endcase
  end

  assign rx_frame_done  = frame_done_q;
  assign rx_frame_error = frame_error_q;
  assign rx_byte_count  = byte_count_q;
  assign rx_last_bit    = last_bit_q;
  assign tx_go          = tx_go_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_comms_sequencer.sv
// Bench for comms_sequencer: directed scenarios plus randomized frames,
// every cycle compared against a slot-arithmetic reference model.
module tb_comms_sequencer;

  localparam int T1 = 1236;
  localparam int T0 = 1172;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_soc = 1'b0, rx_eoc = 1'b0, rx_data_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [2:0] rx_data_bits = '0;
  logic       rx_sequence_error = 1'b0, rx_parity_error = 1'b0;
  logic       app_tx_req = 1'b0, tx_done = 1'b0;
  logic       rx_frame_done, rx_frame_error, rx_last_bit, tx_go, busy;
  logic [7:0] rx_byte_count;

  always #5 clk = ~clk;

  comms_sequencer #(.FDT_LAST_BIT_1(T1), .FDT_LAST_BIT_0(T0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_soc(rx_soc), .rx_eoc(rx_eoc),
    .rx_data(rx_data), .rx_data_bits(rx_data_bits), .rx_data_valid(rx_data_valid),
    .rx_sequence_error(rx_sequence_error), .rx_parity_error(rx_parity_error),
    .app_tx_req(app_tx_req), .tx_done(tx_done),
    .rx_frame_done(rx_frame_done), .rx_frame_error(rx_frame_error),
    .rx_byte_count(rx_byte_count), .rx_last_bit(rx_last_bit),
    .tx_go(tx_go), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: mode 0 idle, 1 in frame, 2 response pending, 3 transmitting
  int m_mode = 0, m_cnt = 0, m_err = 0, m_lb = 0, m_e = 0, m_t = 0;
  int e_done = 0, e_err = 0, e_cnt = 0, e_lb = 0, e_go = 0, e_busy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int bit_of(input logic [7:0] d, input logic [2:0] b);
    int sh;
    sh = (b == 3'd0) ? 7 : int'(b) - 1;
    return int'(d[sh]);
  endfunction

  // Model consumes the inputs of cycle cyc and predicts outputs of cycle cyc+1.
  task automatic model_step();
    int d;
    e_done = 0;
    e_go = 0;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_err = 0; m_lb = 0;
      e_err = 0; e_cnt = 0; e_lb = 0;
    end else begin
      case (m_mode)
        0: if (rx_soc) begin m_mode = 1; m_cnt = 0; m_err = 0; m_lb = 0; end
        1: begin
          if (rx_data_valid) begin
            if (m_cnt < 255) m_cnt++;
            m_lb = bit_of(rx_data, rx_data_bits);
          end
          if (rx_sequence_error || rx_parity_error) m_err = 1;
          if (rx_eoc) begin
            e_done = 1;
            e_err = (m_err != 0 || m_cnt == 0) ? 1 : 0;
            e_cnt = m_cnt;
            e_lb = m_lb;
            if (e_err != 0) m_mode = 0;
            else begin m_mode = 2; m_e = cyc; m_t = (m_lb != 0) ? T1 : T0; end
          end else if (rx_soc) begin
            m_cnt = 0; m_err = 0; m_lb = 0;
          end
        end
        2: begin
          if (rx_soc) begin m_mode = 1; m_cnt = 0; m_err = 0; m_lb = 0; end
          else begin
            d = cyc + 1 - m_e - m_t;
            if (d >= 0 && (d % 128) == 0 && app_tx_req) begin e_go = 1; m_mode = 3; end
          end
        end
        default: if (tx_done) m_mode = 0;
      endcase
    end
    e_busy = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("tx_go", tx_go, e_go);
    chk("frame_done", rx_frame_done, e_done);
    chk("frame_error", rx_frame_error, e_err);
    chk("byte_count", rx_byte_count, e_cnt);
    chk("last_bit", rx_last_bit, e_lb);
    chk("busy", busy, e_busy);
    rx_soc = 0; rx_eoc = 0; rx_data_valid = 0;
    rx_sequence_error = 0; rx_parity_error = 0; tx_done = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] b, input logic perr);
    rx_data = d; rx_data_bits = b; rx_data_valid = 1; rx_parity_error = perr;
    tick(); tick();
  endtask

  task automatic end_frame(output int e);
    rx_eoc = 1; e = cyc; tick();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_go(input int maxc, output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      tick();
      if (tx_go === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic finish_tx();
    app_tx_req = 0;
    repeat (5) tick();
    tx_done = 1; tick();
  endtask

  task automatic pulse_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  initial begin
    int e0, at, nb, pol, rise, cancel;
    tick(); tick();
    chk("rst_busy", busy, 0);
    rst_n = 1; tick();

    // 1: two-byte frame, last bit 0, request already up
    rx_soc = 1; tick();
    send_byte(8'h93, 3'd0, 1'b0); send_byte(8'h20, 3'd0, 1'b0);
    app_tx_req = 1; end_frame(e0);
    chk("t1_done", rx_frame_done, 1); chk("t1_cnt", rx_byte_count, 2);
    chk("t1_err", rx_frame_error, 0); chk("t1_lb", rx_last_bit, 0);
    wait_go(1300, at); chk("t1_fdt", at - e0, 1172); chk("t1_busy", busy, 1);
    finish_tx(); chk("t1_idle", busy, 0);

    // 2: short frames, bit6 = 0 then bit6 = 1
    rx_soc = 1; tick(); send_byte(8'h26, 3'd7, 1'b0);
    app_tx_req = 1; end_frame(e0); wait_go(1300, at); chk("t2_fdt0", at - e0, 1172); finish_tx();
    rx_soc = 1; tick(); send_byte(8'h52, 3'd7, 1'b0);
    app_tx_req = 1; end_frame(e0); wait_go(1300, at); chk("t2_fdt1", at - e0, 1236); finish_tx();

    // 3: late requests land on the 128-cycle grid
    rx_soc = 1; tick(); send_byte(8'h52, 3'd7, 1'b0); end_frame(e0);
    run_to(e0 + 1300); app_tx_req = 1; wait_go(400, at); chk("t3_late1", at - e0, 1364); finish_tx();
    rx_soc = 1; tick(); send_byte(8'h52, 3'd7, 1'b0); end_frame(e0);
    run_to(e0 + 1364); app_tx_req = 1; wait_go(400, at); chk("t3_late2", at - e0, 1492); finish_tx();

    // 4: parity error frame and empty frame
    rx_soc = 1; tick();
    send_byte(8'h11, 3'd0, 1'b0); send_byte(8'h22, 3'd0, 1'b1); send_byte(8'h33, 3'd0, 1'b0);
    app_tx_req = 1; end_frame(e0);
    chk("t4_err", rx_frame_error, 1); chk("t4_cnt", rx_byte_count, 3);
    wait_go(3000, at); chk("t4_nogo", at, -1);
    rx_soc = 1; tick(); end_frame(e0);
    chk("t4_empty_err", rx_frame_error, 1); chk("t4_empty_cnt", rx_byte_count, 0);
    app_tx_req = 0; tick();

    // 5: cancel in FDT_WAIT, then normal; then soc coincident with slot
    rx_soc = 1; tick(); send_byte(8'h80, 3'd0, 1'b0); end_frame(e0);
    run_to(e0 + 500); rx_soc = 1; tick(); app_tx_req = 1;
    send_byte(8'h80, 3'd0, 1'b0); run_to(e0 + T1 + 2);
    chk("t5_cancel", busy, 1);
    end_frame(e0); wait_go(1300, at); chk("t5_next", at - e0, 1236); finish_tx();
    rx_soc = 1; tick(); send_byte(8'h80, 3'd0, 1'b0);
    app_tx_req = 1; end_frame(e0); run_to(e0 + T1 - 1);
    rx_soc = 1; tick(); chk("t5_coinc", tx_go, 0);
    app_tx_req = 0; end_frame(e0); chk("t5_coinc_err", rx_frame_error, 1);

    // 6: reset mid-wait, then rx ignored while transmitting
    rx_soc = 1; tick(); send_byte(8'h01, 3'd1, 1'b0); end_frame(e0);
    run_to(e0 + 800); pulse_reset(); app_tx_req = 1;
    chk("t6_rst_cnt", rx_byte_count, 0); chk("t6_rst_lb", rx_last_bit, 0);
    wait_go(3000, at); chk("t6_nogo", at, -1);
    rx_soc = 1; tick(); send_byte(8'h01, 3'd1, 1'b0); end_frame(e0);
    wait_go(1300, at); chk("t6_go", at - e0, 1236);
    rx_soc = 1; tick(); send_byte(8'h00, 3'd0, 1'b0); rx_eoc = 1; tick();
    chk("t6_ignored", rx_frame_done, 0); finish_tx();

    // byte counter saturation
    rx_soc = 1; tick();
    for (int i = 0; i < 260; i++) begin rx_data = 8'hFF; rx_data_bits = 3'd0; rx_data_valid = 1; tick(); end
    end_frame(e0); chk("sat_cnt", rx_byte_count, 255); pulse_reset();

    // randomized frames and request timing
    for (int it = 0; it < 15; it++) begin
      nb = $urandom_range(0, 4);
      pol = $urandom_range(0, 2);
      rx_soc = 1; tick();
      for (int b = 0; b < nb; b++) begin
        rx_data = 8'($urandom); rx_data_bits = 3'($urandom);
        rx_sequence_error = ($urandom_range(0, 9) == 0);
        rx_parity_error = ($urandom_range(0, 9) == 0);
        rx_data_valid = 1; tick(); tick();
      end
      app_tx_req = (pol == 0);
      end_frame(e0);
      rise = e0 + $urandom_range(1, 1500);
      cancel = ($urandom_range(0, 4) == 0) ? e0 + $urandom_range(1, 1400) : -1;
      for (int k = 0; k < 1700; k++) begin
        if (pol == 1 && cyc == rise) app_tx_req = 1;
        if (cyc == cancel) rx_soc = 1;
        tick();
        if (tx_go === 1'b1) begin
          app_tx_req = 0;
          repeat ($urandom_range(1, 20)) tick();
          tx_done = 1; tick();
          break;
        end
      end
      app_tx_req = 0;
      if (busy === 1'b1) pulse_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
